// File: rtl/r4_pkg.sv
// Shared types for the sequential radix-4 butterfly: FSM states, lane count, bin index.
package r4_pkg;

    localparam int NLANE = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        STREAM = 2'd2
    } r4_state_e;

    typedef logic [1:0] r4_idx_t;

endpackage

// File: rtl/r4_core.sv
// Combinational 4-point DFT butterfly with W+2 bit growth, optional inverse and /4 scaling.
module r4_core
    import r4_pkg::*;
#(
    parameter int W     = 4,
    parameter int SCALE = 0
) (
    input  logic [NLANE*W-1:0]     in_xr_i,
    input  logic [NLANE*W-1:0]     in_xi_i,
    input  logic                   inv_i,
    output logic [NLANE*(W+2)-1:0] out_xr_o,
    output logic [NLANE*(W+2)-1:0] out_xi_o
);

    localparam int WO = W + 2;

    logic signed [WO-1:0] xr [NLANE];
    logic signed [WO-1:0] xi [NLANE];
    logic signed [WO-1:0] yr [NLANE];
    logic signed [WO-1:0] yi [NLANE];
    logic signed [WO-1:0] b1r, b1i, b3r, b3i;

    // Floor truncation: arithmetic shift keeps the sign fill at full W+2 width.
    function automatic logic signed [WO-1:0] scl(input logic signed [WO-1:0] v);
        return (SCALE != 0) ? (v >>> 2) : v;
    endfunction

    always_comb begin
        for (int unsigned n = 0; n < NLANE; n++) begin
            xr[n] = {{2{in_xr_i[n*W+W-1]}}, in_xr_i[n*W +: W]};
            xi[n] = {{2{in_xi_i[n*W+W-1]}}, in_xi_i[n*W +: W]};
        end
    end

    always_comb begin
        b1r   = xr[0] + xi[1] - xr[2] - xi[3];
        b1i   = xi[0] - xr[1] - xi[2] + xr[3];
        b3r   = xr[0] - xi[1] - xr[2] + xi[3];
        b3i   = xi[0] + xr[1] - xi[2] - xr[3];
        yr[0] = xr[0] + xr[1] + xr[2] + xr[3];
        yi[0] = xi[0] + xi[1] + xi[2] + xi[3];
        yr[2] = xr[0] - xr[1] + xr[2] - xr[3];
        yi[2] = xi[0] - xi[1] + xi[2] - xi[3];
        yr[1] = inv_i ? b3r : b1r;
        yi[1] = inv_i ? b3i : b1i;
        yr[3] = inv_i ? b1r : b3r;
        yi[3] = inv_i ? b1i : b3i;
    end

    always_comb begin
        for (int unsigned n = 0; n < NLANE; n++) begin
            out_xr_o[n*WO +: WO] = scl(yr[n]);
            out_xi_o[n*WO +: WO] = scl(yi[n]);
        end
    end

endmodule

// File: rtl/r4_butter_seq.sv
// Registered radix-4 butterfly: capture one sample set, compute in one cycle,
// then stream X[0]..X[3] under valid/ready backpressure.
module r4_butter_seq
    import r4_pkg::*;
#(
    parameter int W     = 4,
    parameter int SCALE = 0
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 inv_i,
    input  logic [NLANE*W-1:0]   in_xr_i,
    input  logic [NLANE*W-1:0]   in_xi_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [W+1:0]         out_xr_o,
    output logic [W+1:0]         out_xi_o,
    output logic [1:0]           out_idx_o,
    output logic                 out_last_o
);

    localparam int WO = W + 2;

    r4_state_e               state_q, state_d;
    r4_idx_t                 k_q, k_d;
    logic                    alive_q;
    logic [NLANE*W-1:0]      xr_q, xr_d, xi_q, xi_d;
    logic                    inv_q, inv_d;
    logic [NLANE*WO-1:0]     yr_q, yr_d, yi_q, yi_d;
    logic [NLANE*WO-1:0]     yr_c, yi_c;

    r4_core #(
        .W     (W),
        .SCALE (SCALE)
    ) u_core (
        .in_xr_i  (xr_q),
        .in_xi_i  (xi_q),
        .inv_i    (inv_q),
        .out_xr_o (yr_c),
        .out_xi_o (yi_c)
    );

    // alive_q holds ready low until the first clock after reset release.
    assign in_ready_o  = alive_q && (state_q == IDLE);
    assign out_valid_o = (state_q == STREAM);
    assign out_idx_o   = k_q;
    assign out_last_o  = out_valid_o && (k_q == 2'd3);
    assign out_xr_o    = yr_q[int'(k_q)*WO +: WO];
    assign out_xi_o    = yi_q[int'(k_q)*WO +: WO];

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        xr_d    = xr_q;
        xi_d    = xi_q;
        inv_d   = inv_q;
        yr_d    = yr_q;
        yi_d    = yi_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready_o) begin
                    xr_d    = in_xr_i;
                    xi_d    = in_xi_i;
                    inv_d   = inv_i;
                    state_d = CALC;
                end
            end
            CALC: begin
                yr_d    = yr_c;
                yi_d    = yi_c;
                k_d     = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (out_ready_i) begin
                    if (k_q == 2'd3) begin
                        k_d     = '0;
                        state_d = IDLE;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            k_q     <= '0;
            alive_q <= 1'b0;
            xr_q    <= '0;
            xi_q    <= '0;
            inv_q   <= 1'b0;
            yr_q    <= '0;
            yi_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            alive_q <= 1'b1;
            xr_q    <= xr_d;
            xi_q    <= xi_d;
            inv_q   <= inv_d;
            yr_q    <= yr_d;
            yi_q    <= yi_d;
        end
    end

endmodule

// File: tb/tb_r4_butter_seq.sv
// Bench for r4_butter_seq: SCALE=0 and SCALE=1 instances side by side, checked
// against a DFT model built from twiddle rotations.
module tb_r4_butter_seq;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid, inv, out_ready;
    logic [4*W-1:0] xr_bus, xi_bus;
    logic           rdy0, rdy1, v0, v1, last0, last1;
    logic [W+1:0]   or0, oi0, or1, oi1;
    logic [1:0]     idx0, idx1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    r4_butter_seq #(.W(W), .SCALE(0)) dut0 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy0),
        .inv_i(inv), .in_xr_i(xr_bus), .in_xi_i(xi_bus), .out_valid_o(v0),
        .out_ready_i(out_ready), .out_xr_o(or0), .out_xi_o(oi0), .out_idx_o(idx0),
        .out_last_o(last0));

    r4_butter_seq #(.W(W), .SCALE(1)) dut1 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy1),
        .inv_i(inv), .in_xr_i(xr_bus), .in_xi_i(xi_bus), .out_valid_o(v1),
        .out_ready_i(out_ready), .out_xr_o(or1), .out_xi_o(oi1), .out_idx_o(idx1),
        .out_last_o(last1));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // X[k] = sum_n x[n] * w^(n*k), w = -j forward, +j inverse.
    task automatic model_bin(input int ar[4], input int ai[4], input bit iv, input int k,
                             input bit scale, output int er, output int ei);
        int r, i, t;
        er = 0;
        ei = 0;
        for (int n = 0; n < 4; n++) begin
            r = ar[n];
            i = ai[n];
            for (int m = 0; m < (n * k) % 4; m++) begin
                t = r;
                if (iv) begin r = -i; i = t;  end
                else    begin r = i;  i = -t; end
            end
            er += r;
            ei += i;
        end
        if (scale) begin
            er = er >>> 2;
            ei = ei >>> 2;
        end
    endtask

    task automatic apply(input int ar[4], input int ai[4], input bit iv);
        for (int n = 0; n < 4; n++) begin
            xr_bus[n*W +: W] = ar[n][W-1:0];
            xi_bus[n*W +: W] = ai[n][W-1:0];
        end
        inv = iv;
    endtask

    task automatic check_beat(input string tag, input int ar[4], input int ai[4],
                              input bit iv, input int k);
        int er, ei;
        check($sformatf("%s_k%0d_valid", tag, k), int'(v0 & v1), 1);
        check($sformatf("%s_k%0d_idx", tag, k), int'(idx0), k);
        check($sformatf("%s_k%0d_idx_s", tag, k), int'(idx1), k);
        check($sformatf("%s_k%0d_last", tag, k), int'(last0), int'(k == 3));
        check($sformatf("%s_k%0d_last_s", tag, k), int'(last1), int'(k == 3));
        model_bin(ar, ai, iv, k, 1'b0, er, ei);
        check($sformatf("%s_k%0d_xr", tag, k), int'($signed(or0)), er);
        check($sformatf("%s_k%0d_xi", tag, k), int'($signed(oi0)), ei);
        model_bin(ar, ai, iv, k, 1'b1, er, ei);
        check($sformatf("%s_k%0d_xr_s", tag, k), int'($signed(or1)), er);
        check($sformatf("%s_k%0d_xi_s", tag, k), int'($signed(oi1)), ei);
    endtask

    // Entered and left at posedge+1. stall_k/abort_k < 0 disables; hold keeps
    // in_valid high with (nr,ni,niv) during the stream.
    task automatic run_set(input string tag, input int ar[4], input int ai[4], input bit iv,
                           input int stall_k, input int abort_k, input bit hold,
                           input int nr[4], input int ni[4], input bit niv);
        int n;
        int vcount;
        apply(ar, ai, iv);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!rdy0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_ready"}, int'(rdy0 & rdy1), 1);
        @(posedge clk); #1;
        if (hold) apply(nr, ni, niv);
        else      in_valid = 1'b0;
        check({tag, "_calc_valid"}, int'(v0 | v1), 0);
        check({tag, "_calc_ready"}, int'(rdy0 | rdy1), 0);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            check_beat(tag, ar, ai, iv, k);
            if (k == abort_k) begin
                #3 rst_n = 1'b0;
                #1;
                check({tag, "_rst_valid"}, int'(v0 | v1), 0);
                check({tag, "_rst_ready"}, int'(rdy0 | rdy1), 0);
                check({tag, "_rst_xr"}, int'(or0 | or1), 0);
                check({tag, "_rst_xi"}, int'(oi0 | oi1), 0);
                check({tag, "_rst_idx"}, int'(idx0 | idx1), 0);
                check({tag, "_rst_last"}, int'(last0 | last1), 0);
                in_valid = 1'b0;
                #2 rst_n = 1'b1;
                @(posedge clk); #1;
                check({tag, "_rel_ready"}, int'(rdy0 & rdy1), 1);
                vcount = 0;
                for (int c = 0; c < 6; c++) begin
                    vcount += int'(v0 | v1);
                    @(posedge clk); #1;
                end
                check({tag, "_rel_no_beats"}, vcount, 0);
                return;
            end
            if (k == stall_k) begin
                out_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(posedge clk); #1;
                    check_beat({tag, "_stall"}, ar, ai, iv, k);
                end
                check({tag, "_stall_ready"}, int'(rdy0 | rdy1), 0);
                out_ready = 1'b1;
            end
            if (hold) check({tag, "_hold_ready"}, int'(rdy0), 0);
            @(posedge clk); #1;
        end
        check({tag, "_done_valid"}, int'(v0 | v1), 0);
        check({tag, "_done_ready"}, int'(rdy0 & rdy1), 1);
    endtask

    initial begin
        int ar[4], ai[4], br[4], bi[4], z[4];
        bit iv;
        z         = '{0, 0, 0, 0};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        inv       = 1'b0;
        xr_bus    = '0;
        xi_bus    = '0;
        #1;
        check("reset_ready", int'(rdy0 | rdy1), 0);
        check("reset_valid", int'(v0 | v1), 0);
        check("reset_xr", int'(or0 | or1), 0);
        check("reset_xi", int'(oi0 | oi1), 0);
        check("reset_idx_last", int'(idx0 | idx1 | {1'b0, last0 | last1}), 0);
        #6;
        check("reset_ready_held", int'(rdy0 | rdy1), 0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        check("release_ready", int'(rdy0 & rdy1), 1);

        ar = '{1, 1, 1, 1};     ai = z;
        run_set("dc", ar, ai, 1'b0, -1, -1, 1'b0, z, z, 1'b0);
        ar = '{0, 1, 0, 0};
        run_set("lane_b_fwd", ar, ai, 1'b0, -1, -1, 1'b0, z, z, 1'b0);
        run_set("lane_b_inv", ar, ai, 1'b1, -1, -1, 1'b0, z, z, 1'b0);
        ar = '{-8, -8, -8, -8}; ai = '{-8, -8, -8, -8};
        run_set("growth", ar, ai, 1'b0, -1, -1, 1'b0, z, z, 1'b0);
        ar = '{-1, 0, 0, 0};    ai = z;
        run_set("floor", ar, ai, 1'b0, -1, -1, 1'b0, z, z, 1'b0);

        ar = '{3, -2, 5, 7};    ai = '{-4, 6, 1, -8};
        br = '{-5, 2, 7, -1};   bi = '{0, -3, 4, 6};
        run_set("stall_hold", ar, ai, 1'b0, 1, -1, 1'b1, br, bi, 1'b1);
        run_set("held_set", br, bi, 1'b1, -1, -1, 1'b0, z, z, 1'b0);

        run_set("abort", ar, ai, 1'b1, -1, 2, 1'b0, z, z, 1'b0);
        run_set("post_abort", br, bi, 1'b0, -1, -1, 1'b0, z, z, 1'b0);

        for (int t = 0; t < 24; t++) begin
            for (int n = 0; n < 4; n++) begin
                ar[n] = int'($urandom_range(15)) - 8;
                ai[n] = int'($urandom_range(15)) - 8;
            end
            iv = 1'($urandom_range(1));
            run_set($sformatf("rnd%0d", t), ar, ai, iv,
                    int'($urandom_range(5)) - 2, -1, 1'b0, z, z, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected finish");
        $fatal(1);
    end

endmodule
